// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-side RAM responder: FSM codes, enables and sel legality.
package data_ram_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic              ChipEnable  = 1'b1;
  localparam logic              WriteEnable = 1'b1;
  localparam logic              RstEnable   = 1'b1;
  localparam logic [DATA_W-1:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'b00,
    DRAM_BUSY = 2'b01,
    DRAM_DONE = 2'b10
  } dram_state_e;

  // Latched copy of a request; the word address is kept separately because its width is a parameter.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } dram_req_t;

  // Byte, aligned halfword, 3-byte and full-word lane patterns are the only writable shapes.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    logic ok;
    case (sel)
      4'b1000, 4'b0100, 4'b0010, 4'b0001,
      4'b1100, 4'b0011, 4'b0111, 4'b1110, 4'b1111: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// One byte lane of the data RAM: synchronous write, asynchronous read, no reset of contents.
module data_ram_bank #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  // Byte write at the rising edge when this lane is enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_ram_responder.sv
// Data-side memory responder: big-endian byte-writable word RAM with configurable wait states.
// WAIT_CYCLES = 0 gives a combinational-read zero-wait responder; otherwise an IDLE/BUSY/DONE FSM.
// Optional macro DATA_RAM_SEL_CHECK_EN adds err_o and suppresses writes with illegal lane patterns.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
`ifdef DATA_RAM_SEL_CHECK_EN
  output logic        err_o,
`endif
  output logic        stallreq_o
);

  logic [SEL_W-1:0]  bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata;

  // Byte offset bits and address bits beyond the RAM depth are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  // Four byte lanes; lane 3 holds data[31:24], the lowest byte address of the word.
  for (genvar l = 0; l < 4; l++) begin : g_bank
    data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk     (clk),
      .we_i    (bank_we[l]),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata[8*l +: 8]),
      .rdata_o (bank_rdata[8*l +: 8])
    );
  end

  if (WAIT_CYCLES == 0) begin : g_zero_wait

    logic wr_req_c;
    logic wr_ok_c;
    logic unused_rst;

    assign unused_rst = rst;
    assign wr_req_c   = (ce_i == ChipEnable) && (we_i == WriteEnable);
`ifdef DATA_RAM_SEL_CHECK_EN
    assign wr_ok_c    = wr_req_c && sel_legal(sel_i);
    assign err_o      = wr_req_c && !sel_legal(sel_i);
`else
    assign wr_ok_c    = wr_req_c;
`endif

    assign bank_we    = wr_ok_c ? sel_i : 4'b0000;
    assign bank_addr  = addr_i[ADDR_W+1:2];
    assign bank_wdata = data_i;
    assign data_o     = ((ce_i == ChipEnable) && (we_i != WriteEnable)) ? bank_rdata : ZeroWord;
    assign stallreq_o = 1'b0;

  end else begin : g_wait

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WAIT_CYCLES - 1);

    dram_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dram_req_t         req_q, req_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stall_c;
    logic [SEL_W-1:0]  we_c;
`ifdef DATA_RAM_SEL_CHECK_EN
    logic              err_q, err_d;
`endif

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        state_q <= DRAM_IDLE;
        cnt_q   <= '0;
        req_q   <= '0;
        waddr_q <= '0;
        rdata_q <= ZeroWord;
`ifdef DATA_RAM_SEL_CHECK_EN
        err_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        req_q   <= req_d;
        waddr_q <= waddr_d;
        rdata_q <= rdata_d;
`ifdef DATA_RAM_SEL_CHECK_EN
        err_q   <= err_d;
`endif
      end
    end

    // Next state, bank write strobes and stall request.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      waddr_d = waddr_q;
      rdata_d = ZeroWord;
      stall_c = 1'b0;
      we_c    = 4'b0000;
`ifdef DATA_RAM_SEL_CHECK_EN
      err_d   = 1'b0;
`endif
      case (state_q)
        DRAM_IDLE: begin
          stall_c = ce_i;
          if (ce_i == ChipEnable) begin
            req_d   = '{we: we_i, sel: sel_i, data: data_i};
            waddr_d = addr_i[ADDR_W+1:2];
            cnt_d   = CntLoad;
            state_d = DRAM_BUSY;
          end
        end
        DRAM_BUSY: begin
          stall_c = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = DRAM_DONE;
            if (req_q.we == WriteEnable) begin
`ifdef DATA_RAM_SEL_CHECK_EN
              if (sel_legal(req_q.sel)) begin
                we_c = req_q.sel;
              end else begin
                err_d = 1'b1;
              end
`else
              we_c = req_q.sel;
`endif
            end else begin
              rdata_d = bank_rdata;
            end
          end
        end
        DRAM_DONE: begin
          state_d = DRAM_IDLE;
        end
        default: begin
          state_d = DRAM_IDLE;
        end
      endcase
    end

    // A reset edge must never commit the pending write.
    assign bank_we    = (rst == RstEnable) ? 4'b0000 : we_c;
    assign bank_addr  = waddr_q;
    assign bank_wdata = req_q.data;
    assign data_o     = rdata_q;
    assign stallreq_o = stall_c;
`ifdef DATA_RAM_SEL_CHECK_EN
    assign err_o      = err_q;
`endif

  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: three instances (WAIT_CYCLES 1, 3, 0) sharing a clock.
module tb_data_ram_responder;

  localparam int unsigned AW = 10;

  logic        clk;
  logic        rst   [3];
  logic        ce    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  sel   [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        stall [3];
`ifdef DATA_RAM_SEL_CHECK_EN
  logic        err   [3];
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .sel_i(sel[0]), .data_i(din[0]), .data_o(dout[0]),
`ifdef DATA_RAM_SEL_CHECK_EN
    .err_o(err[0]),
`endif
    .stallreq_o(stall[0]));

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .sel_i(sel[1]), .data_i(din[1]), .data_o(dout[1]),
`ifdef DATA_RAM_SEL_CHECK_EN
    .err_o(err[1]),
`endif
    .stallreq_o(stall[1]));

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[2]), .ce_i(ce[2]), .we_i(we[2]), .addr_i(addr[2]),
    .sel_i(sel[2]), .data_i(din[2]), .data_o(dout[2]),
`ifdef DATA_RAM_SEL_CHECK_EN
    .err_o(err[2]),
`endif
    .stallreq_o(stall[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] dat, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.sel = s; v.data = dat; v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  // One wait-mode access: request for a single cycle, then ce dropped while the DUT stalls.
  task automatic txn(input int d, input vec_t v, input string nm);
    int stalls;
    int nonzero;
    bit done;
    logic [31:0] exp_d;
    stalls = 0; nonzero = 0; done = 1'b0;
    sb_q.push_back(v.exp_d);
    @(posedge clk); #1;
    ce[d] = 1'b1; we[d] = v.we; addr[d] = v.addr; sel[d] = v.sel; din[d] = v.data;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (stall[d]) begin
        stalls++;
        if (dout[d] != 32'h0) nonzero++;
        @(posedge clk); #1;
        ce[d] = 1'b0; we[d] = 1'b0; din[d] = 32'hDEAD_0000; sel[d] = 4'b0000;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: stalls=%0d without reaching DONE", nm, stalls);
      void'(sb_q.pop_front());
    end else begin
      exp_d = sb_q.pop_front();
      check({nm, "_data"}, dout[d], exp_d);
      check({nm, "_stall_cycles"}, 32'(stalls), 32'(wait_of(d) + 1));
      check({nm, "_data_zero_while_busy"}, 32'(nonzero), 32'd0);
`ifdef DATA_RAM_SEL_CHECK_EN
      check({nm, "_err"}, 32'(err[d]), 32'(v.exp_e));
`endif
    end
  endtask

  // One zero-wait access: response compared in the same cycle.
  task automatic zw(input vec_t v, input string nm);
    logic [31:0] exp_d;
    sb_q.push_back(v.exp_d);
    @(posedge clk); #1;
    ce[2] = 1'b1; we[2] = v.we; addr[2] = v.addr; sel[2] = v.sel; din[2] = v.data;
    #4;
    exp_d = sb_q.pop_front();
    check({nm, "_data"}, dout[2], exp_d);
    check({nm, "_stall"}, 32'(stall[2]), 32'd0);
`ifdef DATA_RAM_SEL_CHECK_EN
    check({nm, "_err"}, 32'(err[2]), 32'(v.exp_e));
`endif
  endtask

  initial begin
    bit chk;
`ifdef DATA_RAM_SEL_CHECK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; sel[d] = '0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #4;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_stall_%0d", d), 32'(stall[d]), 32'd0);
      check($sformatf("reset_data_%0d", d), dout[d], 32'h0);
    end

    // WAIT_CYCLES=1 vector table; expectations depend on whether illegal sel is suppressed.
    vecs.push_back(mk(1, 32'h100, 4'b1111, 32'h1122_3344, 32'h0, 0));
    vecs.push_back(mk(0, 32'h100, 4'b0000, 32'h0, 32'h1122_3344, 0));
    vecs.push_back(mk(1, 32'h100, 4'b0100, 32'hAAAA_AAAA, 32'h0, 0));
    vecs.push_back(mk(0, 32'h100, 4'b1111, 32'h0, 32'h11AA_3344, 0));
    vecs.push_back(mk(1, 32'h200, 4'b1111, 32'h0102_0304, 32'h0, 0));
    vecs.push_back(mk(0, 32'h200, 4'b1111, 32'h0, 32'h0102_0304, 0));
    vecs.push_back(mk(1, 32'h102, 4'b0011, 32'h5566_7788, 32'h0, 0));
    vecs.push_back(mk(0, 32'h101, 4'b0001, 32'h0, 32'h11AA_7788, 0));
    vecs.push_back(mk(0, 32'h1200, 4'b1111, 32'h0, 32'h0102_0304, 0));
    vecs.push_back(mk(1, 32'h300, 4'b1111, 32'hCAFE_BABE, 32'h0, 0));
    vecs.push_back(mk(1, 32'h300, 4'b0000, 32'hFFFF_FFFF, 32'h0, chk));
    vecs.push_back(mk(0, 32'h300, 4'b1111, 32'h0, 32'hCAFE_BABE, 0));
    vecs.push_back(mk(1, 32'h100, 4'b1010, 32'hFFFF_FFFF, 32'h0, chk));
    vecs.push_back(mk(0, 32'h100, 4'b1111, 32'h0, chk ? 32'h11AA_7788 : 32'hFFAA_FF88, 0));
    vecs.push_back(mk(1, 32'h100, 4'b0111, 32'h0000_0000, 32'h0, 0));
    vecs.push_back(mk(0, 32'h100, 4'b1111, 32'h0, chk ? 32'h1100_0000 : 32'hFF00_0000, 0));
    for (int i = 0; i < vecs.size(); i++) txn(0, vecs[i], $sformatf("w1_v%0d", i));

    // Reset during BUSY of a write: the write is dropped.
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h200; sel[0] = 4'b1111; din[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ce[0] = 1'b0; rst[0] = 1'b1;
    #4 check("rst_busy_stall", 32'(stall[0]), 32'd1);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    #4;
    check("rst_after_stall", 32'(stall[0]), 32'd0);
    check("rst_after_data", dout[0], 32'h0);
    txn(0, mk(0, 32'h200, 4'b1111, 32'h0, 32'h0102_0304, 0), "rst_readback");

    // WAIT_CYCLES=3 back-to-back accesses.
    txn(1, mk(1, 32'h40, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0), "w3_wr0");
    txn(1, mk(0, 32'h40, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0), "w3_rd0");
    txn(1, mk(1, 32'h40, 4'b1000, 32'h1212_1212, 32'h0, 0), "w3_wr1");
    txn(1, mk(0, 32'h40, 4'b0000, 32'h0, 32'h12AD_BEEF, 0), "w3_rd1");

    // Zero-wait mode.
    zw(mk(1, 32'h100, 4'b1111, 32'h1122_3344, 32'h0, 0), "w0_wr0");
    zw(mk(0, 32'h100, 4'b1111, 32'h0, 32'h1122_3344, 0), "w0_rd0");
    zw(mk(1, 32'h100, 4'b0100, 32'hAAAA_AAAA, 32'h0, 0), "w0_wr1");
    zw(mk(0, 32'h100, 4'b1111, 32'h0, 32'h11AA_3344, 0), "w0_rd1");
    zw(mk(1, 32'h100, 4'b1010, 32'hFFFF_FFFF, 32'h0, chk), "w0_wr2");
    zw(mk(0, 32'h100, 4'b1111, 32'h0, chk ? 32'h11AA_3344 : 32'hFFAA_FF44, 0), "w0_rd2");
    @(posedge clk); #1;
    ce[2] = 1'b0;
    #4 check("w0_idle_data", dout[2], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
